// File: rtl/uctl_psync_pkg.sv
// Shared types and helpers for the multi-channel pulse synchronizer
// (uctl_pulse_sync_mc and its per-channel slice uctl_psync_chan).
package uctl_psync_pkg;

  // Per-channel clock1 handshake state.
  typedef enum logic [1:0] {
    SETTLE   = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } psync_state_e;

  // Number of bits needed to hold values 0 .. value-1 (value >= 2).
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uctl_psync_chan.sv
// One channel of the clock1 -> clock2 pulse/data synchronizer.
// A toggle request (req_tgl) crosses to clock2 and is acknowledged back;
// pulses arriving while a transfer is in flight are counted in pend and
// launched (or merged when COALESCE != 0) once the ack returns.
// Optional sticky drop flag: define UCTL_PSYNC_OVF_STATUS_EN.
module uctl_psync_chan
  import uctl_psync_pkg::*;
#(
  parameter int unsigned DATA_WD     = 8,
  parameter int unsigned PEND_MAX    = 3,
  parameter int unsigned COALESCE    = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clock1,
  input  logic               clock1Rst_n,
  input  logic               clock2,
  input  logic               clock2Rst_n,
  input  logic               pulse_in,
  input  logic [DATA_WD-1:0] data_in,
  input  logic               ovf_clr,
  output logic               busy,
  output logic               overflow,
  output logic               pulse_out,
  output logic [DATA_WD-1:0] data_out
);

  localparam int unsigned        PEND_WD   = clog2_f(PEND_MAX + 1);
  localparam logic [PEND_WD-1:0] PEND_FULL = PEND_WD'(PEND_MAX);

  // clock1 domain
  psync_state_e             state_q, state_d;
  logic [PEND_WD-1:0]       pend_q, pend_d;
  logic [DATA_WD-1:0]       hold_q, hold_d;
  logic [DATA_WD-1:0]       launch_q, launch_d;
  logic                     req_tgl_q, req_tgl_d;
  logic [SYNC_STAGES-1:0]   ack_sync_q, ack_sync_d;
  logic                     ack_sync;
  logic                     accept;
  logic                     drop;

  // clock2 domain
  logic [SYNC_STAGES-1:0]   req_sync_q, req_sync_d;
  logic                     req_sync;
  logic                     req_dly_q, req_dly_d;
  logic [DATA_WD-1:0]       data_q, data_d;

  // clock1: accept/drop, pend bookkeeping, handshake FSM next state
  always_comb begin
    state_d    = state_q;
    launch_d   = launch_q;
    req_tgl_d  = req_tgl_q;
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], req_dly_q};
    ack_sync   = ack_sync_q[SYNC_STAGES-1];
    accept     = pulse_in && (pend_q != PEND_FULL);
    drop       = pulse_in && (pend_q == PEND_FULL);
    hold_d     = accept ? data_in : hold_q;
    pend_d     = accept ? (pend_q + PEND_WD'(1)) : pend_q;

    unique case (state_q)
      SETTLE: begin
        if (ack_sync == req_tgl_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if ((pend_q != '0) || accept) begin
          req_tgl_d = ~req_tgl_q;
          // launch takes the freshly written hold value on a same-cycle accept
          launch_d  = hold_d;
          pend_d    = (COALESCE != 0) ? '0 : (pend_d - PEND_WD'(1));
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == req_tgl_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  // clock1: FSM state register and datapath flops
  always_ff @(posedge clock1 or negedge clock1Rst_n) begin
    if (!clock1Rst_n) begin
      state_q    <= SETTLE;
      pend_q     <= '0;
      hold_q     <= '0;
      launch_q   <= '0;
      req_tgl_q  <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      launch_q   <= launch_d;
      req_tgl_q  <= req_tgl_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  // SETTLE only counts as busy while the ack still disagrees, so the channel
  // reads idle straight out of a clean reset.
  always_comb begin
    busy = (state_q == WAIT_ACK) || (pend_q != '0) ||
           ((state_q == SETTLE) && (ack_sync != req_tgl_q));
  end

`ifdef UCTL_PSYNC_OVF_STATUS_EN
  logic ovf_q, ovf_d;

  // clock1: sticky drop flag, set beats a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // clock1: drop flag register
  always_ff @(posedge clock1 or negedge clock1Rst_n) begin
    if (!clock1Rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = drop ^ ovf_clr;
  assign overflow   = 1'b0;
`endif

  // clock2: request synchronizer, edge detect and data capture
  always_comb begin
    req_sync_d = {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
    req_sync   = req_sync_q[SYNC_STAGES-1];
    req_dly_d  = req_sync;
    data_d     = (req_sync_d[SYNC_STAGES-1] != req_sync) ? launch_q : data_q;
    pulse_out  = req_sync ^ req_dly_q;
    data_out   = data_q;
  end

  // clock2: synchronizer, delay and data flops
  always_ff @(posedge clock2 or negedge clock2Rst_n) begin
    if (!clock2Rst_n) begin
      req_sync_q <= '0;
      req_dly_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      req_sync_q <= req_sync_d;
      req_dly_q  <= req_dly_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: rtl/uctl_pulse_sync_mc.sv
// Multi-channel clock1 -> clock2 pulse/data synchronizer.
// NUM_CH independent uctl_psync_chan slices; BYPASS wires inputs straight
// through. Optional sticky overflow status: define UCTL_PSYNC_OVF_STATUS_EN.
module uctl_pulse_sync_mc
  import uctl_psync_pkg::*;
#(
  parameter int unsigned BYPASS      = 0,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_WD     = 8,
  parameter int unsigned PEND_MAX    = 3,
  parameter int unsigned COALESCE    = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clock1,
  input  logic                      clock1Rst_n,
  input  logic                      clock2,
  input  logic                      clock2Rst_n,
  input  logic [NUM_CH-1:0]         pulseIn,
  input  logic [NUM_CH*DATA_WD-1:0] dataIn,
  input  logic [NUM_CH-1:0]         ovfClr,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         overflow,
  output logic [NUM_CH-1:0]         pulseOut,
  output logic [NUM_CH*DATA_WD-1:0] dataOut
);

  if (BYPASS != 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clock1, clock1Rst_n, clock2, clock2Rst_n, ovfClr};
    assign pulseOut      = pulseIn;
    assign dataOut       = dataIn;
    assign busy          = '0;
    assign overflow      = '0;
  end else begin : g_sync
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      uctl_psync_chan #(
        .DATA_WD     (DATA_WD),
        .PEND_MAX    (PEND_MAX),
        .COALESCE    (COALESCE),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clock1      (clock1),
        .clock1Rst_n (clock1Rst_n),
        .clock2      (clock2),
        .clock2Rst_n (clock2Rst_n),
        .pulse_in    (pulseIn[k]),
        .data_in     (dataIn[k*DATA_WD +: DATA_WD]),
        .ovf_clr     (ovfClr[k]),
        .busy        (busy[k]),
        .overflow    (overflow[k]),
        .pulse_out   (pulseOut[k]),
        .data_out    (dataOut[k*DATA_WD +: DATA_WD])
      );
    end
  end

endmodule

// File: tb/tb_uctl_pulse_sync_mc.sv
// Directed bench for uctl_pulse_sync_mc: default build, a COALESCE=1/PEND_MAX=7
// instance and a BYPASS instance. Output pulses are logged per channel on the
// clock2 falling edge and compared against hand-computed sequences.
module tb_uctl_pulse_sync_mc;

`ifdef UCTL_PSYNC_OVF_STATUS_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic        clock1, clock2, rst1_n, rst2_n;
  logic [3:0]  pulse_in, ovf_clr, busy, overflow, pulse_out;
  logic [31:0] data_in, data_out;
  logic [3:0]  pulse_c, ovf_clr_c, busy_c, overflow_c, pulse_out_c;
  logic [31:0] data_c, data_out_c;
  logic [3:0]  pulse_b, ovf_clr_b, busy_b, overflow_b, pulse_out_b;
  logic [31:0] data_b, data_out_b;

  int tests = 0;
  int fails = 0;
  int hp1 = 5;
  int hp2 = 5;

  int         cnt   [4] = '{default: 0};
  int         cnt_c [4] = '{default: 0};
  logic [7:0] log_d [4][1024];
  logic [7:0] log_c [4][1024];

  uctl_pulse_sync_mc dut (
    .clock1(clock1), .clock1Rst_n(rst1_n), .clock2(clock2), .clock2Rst_n(rst2_n),
    .pulseIn(pulse_in), .dataIn(data_in), .ovfClr(ovf_clr),
    .busy(busy), .overflow(overflow), .pulseOut(pulse_out), .dataOut(data_out)
  );

  uctl_pulse_sync_mc #(.COALESCE(1), .PEND_MAX(7)) dut_c (
    .clock1(clock1), .clock1Rst_n(rst1_n), .clock2(clock2), .clock2Rst_n(rst2_n),
    .pulseIn(pulse_c), .dataIn(data_c), .ovfClr(ovf_clr_c),
    .busy(busy_c), .overflow(overflow_c), .pulseOut(pulse_out_c), .dataOut(data_out_c)
  );

  uctl_pulse_sync_mc #(.BYPASS(1)) dut_b (
    .clock1(clock1), .clock1Rst_n(rst1_n), .clock2(clock2), .clock2Rst_n(rst2_n),
    .pulseIn(pulse_b), .dataIn(data_b), .ovfClr(ovf_clr_b),
    .busy(busy_b), .overflow(overflow_b), .pulseOut(pulse_out_b), .dataOut(data_out_b)
  );

  initial begin
    clock1 = 1'b0;
    forever #(hp1) clock1 = ~clock1;
  end

  initial begin
    clock2 = 1'b0;
    #2;
    forever #(hp2) clock2 = ~clock2;
  end

  always @(negedge clock2) begin
    for (int k = 0; k < 4; k++) begin
      if (pulse_out[k] === 1'b1) begin
        log_d[k][cnt[k] % 1024] = data_out[k*8 +: 8];
        cnt[k] = cnt[k] + 1;
      end
      if (pulse_out_c[k] === 1'b1) begin
        log_c[k][cnt_c[k] % 1024] = data_out_c[k*8 +: 8];
        cnt_c[k] = cnt_c[k] + 1;
      end
    end
  end

  task automatic tick1(input int n);
    repeat (n) @(posedge clock1);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clock1);
      #1;
      if (busy === 4'h0 && busy_c === 4'h0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clock2);
    #1;
  endtask

  task automatic test_reset();
    tick1(3);
    tests++; if (busy !== 4'h0) begin fails++; $display("FAIL reset_busy got=%h exp=0", busy); end
    tests++; if (overflow !== 4'h0) begin fails++; $display("FAIL reset_ovf got=%h exp=0", overflow); end
    tests++; if (pulse_out !== 4'h0) begin fails++; $display("FAIL reset_pulse got=%h exp=0", pulse_out); end
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", data_out); end
    tests++; if ({busy_c, overflow_c, pulse_out_c} !== 12'h0 || data_out_c !== 32'h0) begin
      fails++; $display("FAIL reset_coal got=%h/%h exp=0/0", {busy_c, overflow_c, pulse_out_c}, data_out_c);
    end
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    tick1(4);
    tests++; if (busy !== 4'h0) begin fails++; $display("FAIL settle_busy got=%h exp=0", busy); end
  endtask

  task automatic test_single();
    int b[4];
    int lat;
    bit ok;
    for (int k = 0; k < 4; k++) b[k] = cnt[k];
    @(posedge clock1); #1;
    pulse_in[0] = 1'b1; data_in[7:0] = 8'hA5;
    @(posedge clock1); #1;
    pulse_in = '0; data_in = '0;
    tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL single_busy got=%b exp=1", busy[0]); end
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock2); #1;
      if (pulse_out[0] === 1'b1) begin lat = i; break; end
    end
    tests++; if (lat < 1 || lat > 3) begin fails++; $display("FAIL single_latency got=%0d exp=1..3", lat); end
    tests++; if (data_out[7:0] !== 8'hA5) begin fails++; $display("FAIL single_dataout got=%h exp=a5", data_out[7:0]); end
    wait_idle(50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_idle_timeout got=busy exp=idle"); end
    tests++; if (cnt[0] - b[0] != 1) begin fails++; $display("FAIL single_count got=%0d exp=1", cnt[0] - b[0]); end
    tests++; if (log_d[0][b[0] % 1024] !== 8'hA5) begin fails++; $display("FAIL single_data got=%h exp=a5", log_d[0][b[0] % 1024]); end
    tests++; if ((cnt[1] - b[1]) + (cnt[2] - b[2]) + (cnt[3] - b[3]) != 0) begin
      fails++; $display("FAIL single_other_ch got=%0d exp=0", (cnt[1] - b[1]) + (cnt[2] - b[2]) + (cnt[3] - b[3]));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] din [3];
    logic [7:0] exp [3];
    int b;
    bit ok;
    din = '{8'h11, 8'h22, 8'h33};
    exp = '{8'h11, 8'h33, 8'h33};
    b = cnt[1];
    @(posedge clock1); #1;
    for (int i = 0; i < 3; i++) begin
      pulse_in[1] = 1'b1; data_in[15:8] = din[i];
      @(posedge clock1); #1;
    end
    pulse_in = '0; data_in = '0;
    wait_idle(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_idle_timeout got=busy exp=idle"); end
    tests++; if (cnt[1] - b != 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", cnt[1] - b); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (log_d[1][(b + i) % 1024] !== exp[i]) begin
        fails++; $display("FAIL b2b_data%0d got=%h exp=%h", i, log_d[1][(b + i) % 1024], exp[i]);
      end
    end
    tests++; if (overflow !== 4'h0) begin fails++; $display("FAIL b2b_ovf got=%h exp=0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [4];
    int b;
    bit ok;
    exp = '{8'h01, 8'h04, 8'h04, 8'h04};
    b = cnt[2];
    @(posedge clock1); #1;
    for (int i = 1; i <= 5; i++) begin
      pulse_in[2] = 1'b1; data_in[23:16] = 8'(i);
      @(posedge clock1); #1;
    end
    pulse_in = '0; data_in = '0;
    wait_idle(150, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_idle_timeout got=busy exp=idle"); end
    tests++; if (cnt[2] - b != 4) begin fails++; $display("FAIL ovf_count got=%0d exp=4", cnt[2] - b); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (log_d[2][(b + i) % 1024] !== exp[i]) begin
        fails++; $display("FAIL ovf_data%0d got=%h exp=%h", i, log_d[2][(b + i) % 1024], exp[i]);
      end
    end
    tick1(5);
    tests++; if (overflow !== {1'b0, EXP_OVF, 2'b00}) begin
      fails++; $display("FAIL ovf_sticky got=%b exp=%b", overflow, {1'b0, EXP_OVF, 2'b00});
    end
    ovf_clr[2] = 1'b1;
    tick1(1);
    ovf_clr = '0;
    tick1(1);
    tests++; if (overflow !== 4'h0) begin fails++; $display("FAIL ovf_clear got=%b exp=0000", overflow); end
  endtask

  task automatic test_coalesce();
    int b;
    bit ok;
    b = cnt_c[0];
    @(posedge clock1); #1;
    pulse_c[0] = 1'b1; data_c[7:0] = 8'h10;
    @(posedge clock1); #1;
    for (int i = 1; i <= 4; i++) begin
      pulse_c[0] = 1'b1; data_c[7:0] = 8'(8'h20 + i);
      @(posedge clock1); #1;
    end
    pulse_c = '0; data_c = '0;
    wait_idle(150, ok);
    tests++; if (!ok) begin fails++; $display("FAIL coal_idle_timeout got=busy exp=idle"); end
    tests++; if (cnt_c[0] - b != 2) begin fails++; $display("FAIL coal_count got=%0d exp=2", cnt_c[0] - b); end
    tests++; if (log_c[0][b % 1024] !== 8'h10) begin fails++; $display("FAIL coal_data0 got=%h exp=10", log_c[0][b % 1024]); end
    tests++; if (log_c[0][(b + 1) % 1024] !== 8'h24) begin fails++; $display("FAIL coal_data1 got=%h exp=24", log_c[0][(b + 1) % 1024]); end
  endtask

  // Reset hits clock1 one ns after the launch edge, before clock2 samples it.
  task automatic test_clk1_reset();
    int b;
    bit ok;
    b = cnt[3];
    @(posedge clock1); #1;
    pulse_in[3] = 1'b1; data_in[31:24] = 8'h77;
    @(posedge clock1); #1;
    pulse_in = '0; data_in = '0;
    rst1_n = 1'b0;
    #3;
    rst1_n = 1'b1;
    tick1(12);
    tests++; if (cnt[3] - b != 0) begin fails++; $display("FAIL rst1_spurious got=%0d exp=0", cnt[3] - b); end
    tests++; if (busy !== 4'h0) begin fails++; $display("FAIL rst1_busy got=%h exp=0", busy); end
    pulse_in[3] = 1'b1; data_in[31:24] = 8'h5C;
    tick1(1);
    pulse_in = '0; data_in = '0;
    wait_idle(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst1_idle_timeout got=busy exp=idle"); end
    tests++; if (cnt[3] - b != 1) begin fails++; $display("FAIL rst1_count got=%0d exp=1", cnt[3] - b); end
    tests++; if (log_d[3][b % 1024] !== 8'h5C) begin fails++; $display("FAIL rst1_data got=%h exp=5c", log_d[3][b % 1024]); end
  endtask

  task automatic test_bypass();
    pulse_b = 4'b1010; data_b = 32'hDEADBEEF; ovf_clr_b = 4'hF;
    #1;
    tests++; if (pulse_out_b !== 4'b1010) begin fails++; $display("FAIL byp_pulse got=%b exp=1010", pulse_out_b); end
    tests++; if (data_out_b !== 32'hDEADBEEF) begin fails++; $display("FAIL byp_data got=%h exp=deadbeef", data_out_b); end
    tests++; if ({busy_b, overflow_b} !== 8'h00) begin fails++; $display("FAIL byp_status got=%h exp=00", {busy_b, overflow_b}); end
    pulse_b = '0; ovf_clr_b = '0;
    #1;
    tests++; if (pulse_out_b !== 4'b0000) begin fails++; $display("FAIL byp_pulse_low got=%b exp=0000", pulse_out_b); end
  endtask

  // Random traffic, a channel is only pulsed while idle so each pulse carries its own data.
  task automatic test_ratio(input int h1, input int h2, input int ncyc);
    logic [7:0] exp_d [4][128];
    int         exp_n [4];
    int         b [4];
    logic [7:0] d;
    bit ok;
    hp1 = h1;
    hp2 = h2;
    tick1(4);
    for (int k = 0; k < 4; k++) begin b[k] = cnt[k]; exp_n[k] = 0; end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock1); #1;
      pulse_in = '0;
      for (int k = 0; k < 4; k++) begin
        if (busy[k] === 1'b0 && $urandom_range(0, 2) == 0) begin
          d = 8'($urandom_range(0, 255));
          pulse_in[k] = 1'b1;
          data_in[k*8 +: 8] = d;
          exp_d[k][exp_n[k]] = d;
          exp_n[k]++;
        end
      end
    end
    @(posedge clock1); #1;
    pulse_in = '0; data_in = '0;
    wait_idle(400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ratio_%0d_%0d_idle_timeout got=busy exp=idle", h1, h2); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (cnt[k] - b[k] != exp_n[k]) begin
        fails++; $display("FAIL ratio_%0d_%0d_count_ch%0d got=%0d exp=%0d", h1, h2, k, cnt[k] - b[k], exp_n[k]);
      end
      for (int i = 0; i < exp_n[k]; i++) begin
        tests++; if (log_d[k][(b[k] + i) % 1024] !== exp_d[k][i]) begin
          fails++; $display("FAIL ratio_%0d_%0d_data_ch%0d_%0d got=%h exp=%h", h1, h2, k, i, log_d[k][(b[k] + i) % 1024], exp_d[k][i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1_n = 1'b0; rst2_n = 1'b0;
    pulse_in = '0; data_in = '0; ovf_clr = '0;
    pulse_c = '0; data_c = '0; ovf_clr_c = '0;
    pulse_b = '0; data_b = '0; ovf_clr_b = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_coalesce();
    test_clk1_reset();
    test_bypass();
    test_ratio(5, 15, 60);
    test_ratio(15, 5, 60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
